// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock controller: state encoding,
// the "enter" nibble marking an unused digit slot, and the strobe blanking
// window that follows an entry timeout.
package lock_pkg;

  typedef enum logic [2:0] {
    LOCKED       = 3'd0,
    UNLOCKED     = 3'd1,
    PROG_CONFIRM = 3'd2,
    LOCKOUT      = 3'd3
  } state_e;

  localparam logic [3:0]  NIBBLE_ENTER = 4'hF;
  localparam int unsigned BLANK_CYCLES = 3;

  // A complete entry has four real digits, i.e. no nibble equals the enter key.
  function automatic logic is_valid_entry(input logic [15:0] code);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (code[4*i +: 4] == NIBBLE_ENTER) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Cycle counter with registered expiry flag.
// Ports: clk, reset (sync, active high), start_i (clear and run; wins over
// stop_i), stop_i (clear and halt), expire_o (high in the cycle the count
// equals N-1; the timer halts on the following edge).
module lock_timer #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic stop_i,
  output logic expire_o
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         run_q, run_d;
  logic         exp_q, exp_d;

  // Next count; the expiry flag is precomputed so it lines up with cnt == N-1.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      cnt_d = '0;
      run_d = 1'b1;
    end else if (stop_i || exp_q) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = cnt_q + W'(1);
    end
    exp_d = run_d && (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      exp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      exp_q <= exp_d;
    end
  end

  assign expire_o = exp_q;

endmodule

// File: rtl/lock_controller.sv
// Keypad lock sequencer: checks completed code entries, drives unlock /
// alarm / program-mode outputs, re-programs the code with confirmation and
// owns the entry-timeout timer.
// Ports: clk, reset (sync, active high); key_pressed_i, new_seq_i,
// sequence_i[15:0], prog_req_i in; times_up_o, unlocked_o, alarm_o,
// prog_mode_o, fail_count_o[1:0], state_dbg_o[2:0] out (all registered).
module lock_controller
  import lock_pkg::*;
#(
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned ENTRY_TIMEOUT  = 50_000_000,
  parameter int unsigned UNLOCK_CYCLES  = 250_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_pressed_i,
  input  logic        new_seq_i,
  input  logic [15:0] sequence_i,
  input  logic        prog_req_i,
  output logic        times_up_o,
  output logic        unlocked_o,
  output logic        alarm_o,
  output logic        prog_mode_o,
  output logic [1:0]  fail_count_o,
  output logic [2:0]  state_dbg_o
);

  localparam int unsigned BLANK_W = $clog2(BLANK_CYCLES + 1);

  state_e             state_q, state_d;
  logic [15:0]        code_q, code_d;
  logic [15:0]        cand_q, cand_d;
  logic [1:0]         fail_q, fail_d;
  logic [1:0]         fail_inc;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic               new_seq_q;
  logic               times_up_q, times_up_d;
  logic               unlocked_q, unlocked_d;
  logic               alarm_q, alarm_d;
  logic               prog_q, prog_d;

  logic rise_c, blank_c, strobe_c, entry_to_c;
  logic entry_exp, unlock_exp, lockout_exp;

  // Accepted strobe: rising new_seq outside the post-timeout window and lockout.
  assign rise_c   = new_seq_i & ~new_seq_q;
  assign blank_c  = times_up_q | (blank_q != '0);
  assign strobe_c = rise_c & ~blank_c & (state_q != LOCKOUT);

  // A key press in the expiry cycle restarts the entry and suppresses the pulse.
  assign entry_to_c = entry_exp & ~key_pressed_i & ~strobe_c & (state_q != LOCKOUT);
  assign fail_inc   = fail_q + 2'd1;

  lock_timer #(.N(ENTRY_TIMEOUT)) u_entry_timer (
    .clk      (clk),
    .reset    (reset),
    .start_i  (key_pressed_i & (state_q != LOCKOUT)),
    .stop_i   (strobe_c | (state_q == LOCKOUT)),
    .expire_o (entry_exp)
  );

  lock_timer #(.N(UNLOCK_CYCLES)) u_unlock_timer (
    .clk      (clk),
    .reset    (reset),
    .start_i  ((state_q == LOCKED) & (state_d == UNLOCKED)),
    .stop_i   (state_q != UNLOCKED),
    .expire_o (unlock_exp)
  );

  lock_timer #(.N(LOCKOUT_CYCLES)) u_lockout_timer (
    .clk      (clk),
    .reset    (reset),
    .start_i  ((state_q != LOCKOUT) & (state_d == LOCKOUT)),
    .stop_i   (state_q != LOCKOUT),
    .expire_o (lockout_exp)
  );

  // Next state, code storage and registered output decode.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    cand_d     = cand_q;
    fail_d     = fail_q;
    times_up_d = entry_to_c;
    blank_d    = blank_q;
    if (times_up_q) begin
      blank_d = BLANK_W'(BLANK_CYCLES);
    end else if (blank_q != '0) begin
      blank_d = blank_q - BLANK_W'(1);
    end

    unique case (state_q)
      LOCKED: begin
        if (strobe_c) begin
          if (sequence_i == code_q) begin
            state_d = UNLOCKED;
            fail_d  = 2'd0;
          end else begin
            fail_d = fail_inc;
            if (fail_inc == 2'(MAX_TRIES)) state_d = LOCKOUT;
          end
        end
      end
      UNLOCKED: begin
        // A strobe takes priority over the unlock expiry.
        if (strobe_c) begin
          if (prog_req_i && is_valid_entry(sequence_i)) begin
            cand_d  = sequence_i;
            state_d = PROG_CONFIRM;
          end else begin
            state_d = LOCKED;
          end
        end else if (unlock_exp) begin
          state_d = LOCKED;
        end
      end
      PROG_CONFIRM: begin
        if (strobe_c) begin
          if (sequence_i == cand_q) code_d = cand_q;
          state_d = LOCKED;
        end else if (entry_to_c) begin
          state_d = LOCKED;
        end
      end
      LOCKOUT: begin
        if (lockout_exp) begin
          state_d = LOCKED;
          fail_d  = 2'd0;
        end
      end
      default: state_d = LOCKED;
    endcase

    unlocked_d = (state_d == UNLOCKED) || (state_d == PROG_CONFIRM);
    alarm_d    = (state_d == LOCKOUT);
    prog_d     = (state_d == PROG_CONFIRM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOCKED;
      code_q     <= DEFAULT_CODE;
      cand_q     <= '0;
      fail_q     <= '0;
      blank_q    <= '0;
      new_seq_q  <= 1'b0;
      times_up_q <= 1'b0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      prog_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      cand_q     <= cand_d;
      fail_q     <= fail_d;
      blank_q    <= blank_d;
      new_seq_q  <= new_seq_i;
      times_up_q <= times_up_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
      prog_q     <= prog_d;
    end
  end

  assign times_up_o   = times_up_q;
  assign unlocked_o   = unlocked_q;
  assign alarm_o      = alarm_q;
  assign prog_mode_o  = prog_q;
  assign fail_count_o = fail_q;
  assign state_dbg_o  = state_q;

endmodule
